life_tracker: RTL and testbench

Tracks the player ship's remaining lives and produces the `dead_count` value consumed by the life-icon draw stages in the VGA pipeline. It sits in the game-logic domain and is clocked by the pixel clock. It takes collision hits and a frame tick derived from vsync, and drives the following registered outputs:
- the death count;
- a one-cycle life-lost pulse;
- an invulnerability flag with a blink-visibility flag;
- a game-over flag.

---
 rtl/life_tracker.sv | 156 +++++++++++++++
 tb/tb_life_tracker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/life_tracker.sv
// rtl/life_tracker.sv - ship life counter with invulnerability window and game-over latch
// Optional blink of the ship sprite during invulnerability: define LIFE_TRACKER_BLINK_EN.
module life_tracker #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       hit_in,
  input  logic       restart_in,
  output logic [3:0] dead_count,
  output logic       life_lost,
  output logic       invuln,
  output logic       ship_visible,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_ALIVE     = 2'd0,
    S_INVULN    = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  localparam logic [3:0] LIVES_C     = 4'(LIVES);
  localparam logic [9:0] INVULN_LAST = 10'(INVULN_FRAMES - 1);

  // Out-of-range parameters would silently truncate the counters, so refuse to elaborate.
  if (LIVES < 1 || LIVES > 15) begin : g_bad_lives
    $error("life_tracker: LIVES must be 1..15");
  end
  if (INVULN_FRAMES < 1 || INVULN_FRAMES >= 1024) begin : g_bad_invuln
    $error("life_tracker: INVULN_FRAMES must be 1..1023");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES >= 64) begin : g_bad_blink
    $error("life_tracker: BLINK_FRAMES must be 1..63");
  end

  state_t     state_q;
  logic [3:0] dead_count_q;
  logic [3:0] dead_count_d;
  logic       life_lost_q;
  logic       invuln_q;
  logic       ship_visible_q;
  logic       game_over_q;
  logic [9:0] frame_cnt_q;
  logic       hit_prev_q;
  logic       vsync_prev_q;
  logic       hit_block_q;
  logic       hit_rise;
  logic       frame_tick;

`ifdef LIFE_TRACKER_BLINK_EN
  localparam logic [5:0] BLINK_LAST  = 6'(BLINK_FRAMES - 1);
  localparam logic       ENTRY_VIS   = 1'b0;
  logic [5:0] blink_cnt_q;
`else
  localparam logic       ENTRY_VIS   = 1'b1;
`endif

  // A hit already held while reset is applied must not count as a rise once reset lifts,
  // so the first post-reset cycle is masked when hit_in was high during reset.
  assign hit_rise   = hit_in & ~hit_prev_q & ~hit_block_q;
  assign frame_tick = vsync_in & ~vsync_prev_q;

  // Saturating increment; dead_count never passes LIVES.
  assign dead_count_d = (dead_count_q == LIVES_C) ? dead_count_q : dead_count_q + 4'd1;

  // Edge-detect history for hit and vsync, plus the reset-release hit mask.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hit_prev_q   <= 1'b0;
      vsync_prev_q <= 1'b0;
      hit_block_q  <= hit_in;
    end else begin
      hit_prev_q   <= hit_in;
      vsync_prev_q <= vsync_in;
      hit_block_q  <= 1'b0;
    end
  end

  // Life FSM with registered outputs; restart overrides any hit in the same cycle.
  always_ff @(posedge pclk) begin
    if (rst || restart_in) begin
      state_q        <= S_ALIVE;
      dead_count_q   <= 4'd0;
      life_lost_q    <= 1'b0;
      invuln_q       <= 1'b0;
      ship_visible_q <= 1'b1;
      game_over_q    <= 1'b0;
      frame_cnt_q    <= 10'd0;
`ifdef LIFE_TRACKER_BLINK_EN
      blink_cnt_q    <= 6'd0;
`endif
    end else begin
      life_lost_q <= 1'b0;
      case (state_q)
        S_ALIVE: begin
          if (hit_rise) begin
            dead_count_q <= dead_count_d;
            life_lost_q  <= 1'b1;
            if (dead_count_d == LIVES_C) begin
              state_q        <= S_GAME_OVER;
              game_over_q    <= 1'b1;
              ship_visible_q <= 1'b0;
            end else begin
              state_q        <= S_INVULN;
              invuln_q       <= 1'b1;
              ship_visible_q <= ENTRY_VIS;
              frame_cnt_q    <= 10'd0;
`ifdef LIFE_TRACKER_BLINK_EN
              blink_cnt_q    <= 6'd0;
`endif
            end
          end
        end
        S_INVULN: begin
          if (frame_tick) begin
            if (frame_cnt_q == INVULN_LAST) begin
              state_q        <= S_ALIVE;
              invuln_q       <= 1'b0;
              ship_visible_q <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 10'd1;
`ifdef LIFE_TRACKER_BLINK_EN
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q    <= 6'd0;
                ship_visible_q <= ~ship_visible_q;
              end else begin
                blink_cnt_q <= blink_cnt_q + 6'd1;
              end
`endif
            end
          end
        end
        S_GAME_OVER: begin
          dead_count_q <= LIVES_C;
        end
        default: begin
          state_q        <= S_ALIVE;
          invuln_q       <= 1'b0;
          game_over_q    <= 1'b0;
          ship_visible_q <= 1'b1;
        end
      endcase
    end
  end

  assign dead_count   = dead_count_q;
  assign life_lost    = life_lost_q;
  assign invuln       = invuln_q;
  assign ship_visible = ship_visible_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_life_tracker.sv
// tb/tb_life_tracker.sv - directed scoreboard bench for life_tracker
module tb_life_tracker;

  localparam int LIVES  = 3;
  localparam int INVF   = 120;
  localparam int BLINKF = 8;
`ifdef LIFE_TRACKER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync_in = 1'b0;
  logic       hit_in = 1'b0;
  logic       restart_in = 1'b0;
  logic [3:0] dead_count;
  logic       life_lost;
  logic       invuln;
  logic       ship_visible;
  logic       game_over;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [3:0] dc;
    logic       ll;
    logic       inv;
    logic       vis;
    logic       go;
  } exp_t;

  exp_t sb[$];

  life_tracker #(.LIVES(LIVES), .INVULN_FRAMES(INVF), .BLINK_FRAMES(BLINKF)) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .hit_in(hit_in), .restart_in(restart_in),
    .dead_count(dead_count), .life_lost(life_lost), .invuln(invuln),
    .ship_visible(ship_visible), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [3:0] dc, input logic ll,
                      input logic inv, input logic vis, input logic go);
    exp_t e;
    e.tag = tag; e.dc = dc; e.ll = ll; e.inv = inv; e.vis = vis; e.go = go;
    sb.push_back(e);
  endtask

  // Drive inputs just after a falling edge, let one rising edge pass, return at next falling edge.
  task automatic step(input logic h, input logic v, input logic r);
    hit_in = h; vsync_in = v; restart_in = r;
    @(negedge pclk);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (dead_count === e.dc) else begin bad++;
      $error("FAIL %s dead_count got %0d want %0d", e.tag, dead_count, e.dc); end
    total++;
    assert (life_lost === e.ll) else begin bad++;
      $error("FAIL %s life_lost got %0b want %0b", e.tag, life_lost, e.ll); end
    total++;
    assert (invuln === e.inv) else begin bad++;
      $error("FAIL %s invuln got %0b want %0b", e.tag, invuln, e.inv); end
    total++;
    assert (ship_visible === e.vis) else begin bad++;
      $error("FAIL %s ship_visible got %0b want %0b", e.tag, ship_visible, e.vis); end
    total++;
    assert (game_over === e.go) else begin bad++;
      $error("FAIL %s game_over got %0b want %0b", e.tag, game_over, e.go); end
  endtask

  function automatic logic blink_vis(input int k);
    if (!BLINK) return 1'b1;
    return ((k / BLINKF) % 2) == 1;
  endfunction

  initial begin
    // Reset with hit held high across release.
    hit_in = 1'b1;
    repeat (3) @(negedge pclk);
    push("reset", 4'd0, 0, 0, 1, 0); check();
    rst = 1'b0;
    push("rst_release_hit_held", 4'd0, 0, 0, 1, 0); step(1, 0, 0); check();
    push("rst_release_hit_held2", 4'd0, 0, 0, 1, 0); step(1, 0, 0); check();
    step(0, 0, 0);

    // Single-cycle hit pulse.
    push("hit1", 4'd1, 1, 1, BLINK ? 1'b0 : 1'b1, 0); step(1, 0, 0); check();
    push("hit1_pulse_end", 4'd1, 0, 1, BLINK ? 1'b0 : 1'b1, 0); step(0, 0, 0); check();

    // 119 frame ticks keep invulnerability; blink pattern checked at each tick.
    for (int k = 1; k < INVF; k++) begin
      push($sformatf("inv_tick%0d", k), 4'd1, 0, 1, blink_vis(k), 0); step(0, 1, 0); check();
      step(1, 0, 0);
      step(0, 0, 0);
    end
    push("inv_exit", 4'd1, 0, 0, 1, 0); step(0, 1, 0); check();
    step(0, 0, 0);

    // Held hit costs one life only.
    push("held_hit_first", 4'd2, 1, 1, BLINK ? 1'b0 : 1'b1, 0); step(1, 0, 0); check();
    repeat (499) step(1, 0, 0);
    push("held_hit_end", 4'd2, 0, 1, BLINK ? 1'b0 : 1'b1, 0); check();
    step(0, 0, 0);
    for (int k = 1; k <= INVF; k++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    push("inv_exit2", 4'd2, 0, 0, 1, 0); check();

    // Third hit ends the game; further hits do nothing.
    push("hit3_gameover", 4'd3, 1, 0, 0, 1); step(1, 0, 0); check();
    push("gameover_hold", 4'd3, 0, 0, 0, 1); step(0, 0, 0); check();
    push("gameover_hit", 4'd3, 0, 0, 0, 1); step(1, 0, 0); check();
    step(0, 0, 0);

    // Restart beats a simultaneous hit rise.
    push("restart_hit", 4'd0, 0, 0, 1, 0); step(1, 0, 1); check();
    push("after_restart_held", 4'd0, 0, 0, 1, 0); step(1, 0, 0); check();
    step(0, 0, 0);

    // Frame tick together with a hit in ALIVE: hit processed.
    push("hit_with_tick", 4'd1, 1, 1, BLINK ? 1'b0 : 1'b1, 0); step(1, 1, 0); check();
    step(0, 0, 0);
    for (int k = 1; k < INVF; k++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    push("exit_edge_hit_ignored", 4'd1, 0, 0, 1, 0); step(1, 1, 0); check();
    push("exit_edge_hit_held", 4'd1, 0, 0, 1, 0); step(1, 0, 0); check();
    step(0, 0, 0);

    // Reset in the middle of invulnerability.
    push("hit_before_rst", 4'd2, 1, 1, BLINK ? 1'b0 : 1'b1, 0); step(1, 0, 0); check();
    rst = 1'b1;
    push("mid_inv_reset", 4'd0, 0, 0, 1, 0); step(1, 0, 0); check();
    rst = 1'b0;
    push("post_reset_held", 4'd0, 0, 0, 1, 0); step(1, 0, 0); check();
    step(0, 0, 0);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
